// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, addresses a zero-wait instruction
// memory, and buffers fetched words in a 2-entry FIFO toward decode.
// Supports back-pressure, redirect with flush, and end-of-program stop.
module ifetch_sequencer #(
  parameter int PC_W     = 5,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 4,
  parameter int LAST_PC  = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc,
  output logic            busy,
  output logic            done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, busy_q, done_q;

  // Queue storage; entry 0 is the head. Not reset: validity lives in cnt_q.
  logic [DATA_W-1:0] qdata_q [2];
  logic [PC_W-1:0]   qpc_q   [2];

  logic              pop;
  logic              redirect_act;
  logic              start_act;
  logic              capture;
  logic [1:0]        wr_idx;
  logic              unused_pc_lo;

  // Word alignment of the redirect target drops the low address bits.
  assign unused_pc_lo = ^redirect_pc[1:0];

  // Next-state logic: redirect outranks start, start outranks normal fetch.
  always_comb begin
    pop          = (cnt_q != 2'd0) && inst_ready;
    redirect_act = redirect && (state_q != S_IDLE);
    start_act    = start && !redirect_act &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));
    capture      = (state_q == S_FETCH) && !redirect_act &&
                   ((cnt_q != 2'd2) || pop);
    wr_idx       = cnt_q - {1'b0, pop};

    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    if (redirect_act) begin
      state_d = S_FETCH;
      pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
      cnt_d   = 2'd0;
    end else if (start_act) begin
      state_d = S_FETCH;
      pc_d    = PC_W'(RESET_PC);
      cnt_d   = 2'd0;
    end else begin
      cnt_d = cnt_q - {1'b0, pop} + {1'b0, capture};
      if (capture) begin
        pc_d = pc_q + PC_W'(PC_STEP);
        if (pc_q == PC_W'(LAST_PC)) begin
          state_d = S_DONE;
        end
      end
    end
  end

  // Control state and registered status outputs, derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_W'(RESET_PC);
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
      busy_q  <= (state_d == S_FETCH) || ((state_d == S_DONE) && (cnt_d != 2'd0));
      done_q  <= (state_d == S_DONE) && (cnt_d == 2'd0);
    end
  end

  // Queue datapath: shift on pop, then write the new word behind the
  // surviving entries (a later write to the same slot overrides the shift).
  always_ff @(posedge clk) begin
    if (pop) begin
      qdata_q[0] <= qdata_q[1];
      qpc_q[0]   <= qpc_q[1];
    end
    if (capture) begin
      qdata_q[wr_idx[0]] <= imem_data;
      qpc_q[wr_idx[0]]   <= pc_q;
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst_data  = valid_q ? qdata_q[0] : '0;
  assign inst_pc    = valid_q ? qpc_q[0] : '0;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer: a cycle table for the straight run,
// restart and back-pressure, plus hand sequences for redirect, redirect/pop
// collision, mid-run reset and redirect arbitration in DONE.
module tb_ifetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [4:0]  inst_pc;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifetch_sequencer #(
    .PC_W(5), .RESET_PC(0), .PC_STEP(4), .LAST_PC(28)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy), .done(done)
  );

  // Program memory contents: a distinct word per address.
  function automatic logic [31:0] word_at(input logic [4:0] a);
    return {8'hA5, 3'b000, a, 8'h5A, 3'b000, a};
  endfunction

  assign imem_data = word_at(imem_addr);

  typedef struct {
    logic       start;
    logic       redir;
    logic [4:0] rpc;
    logic       ready;
    logic       ev;
    logic [4:0] epc;
    logic [4:0] eaddr;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic rd, input logic [4:0] rp,
                     input logic rdy, input logic ev, input logic [4:0] epc,
                     input logic [4:0] ea, input logic eb, input logic ed);
    vec_t v;
    v.start = st; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = ea; v.ebusy = eb; v.edone = ed;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check(input string tag, input logic ev, input logic [4:0] epc,
                       input logic [4:0] ea, input logic eb, input logic ed);
    cmp({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, ev});
    cmp({tag, ".pc"},    {27'd0, inst_pc},    ev ? {27'd0, epc} : 32'd0);
    cmp({tag, ".data"},  inst_data,           ev ? word_at(epc) : 32'd0);
    cmp({tag, ".addr"},  {27'd0, imem_addr},  {27'd0, ea});
    cmp({tag, ".busy"},  {31'd0, busy},       {31'd0, eb});
    cmp({tag, ".done"},  {31'd0, done},       {31'd0, ed});
  endtask

  task automatic drive(input logic st, input logic rd, input logic [4:0] rp,
                       input logic rdy);
    start = st; redirect = rd; redirect_pc = rp; inst_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0);

    // Straight run 0..28, DONE, restart from DONE, then back-pressure.
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 1, 1, 5'(4 * (k - 1)), 5'((4 * k) % 32), 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 4, 1, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 1, 0, 8, 1, 0);
    add(0, 0, 0, 1, 1, 4,  12, 1, 0);
    add(0, 0, 0, 1, 1, 8,  16, 1, 0);
    add(0, 0, 0, 1, 1, 12, 20, 1, 0);
    add(0, 0, 0, 1, 1, 16, 24, 1, 0);

    tick();
    tick();
    check("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
      tick();
      check($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr,
            tbl[i].ebusy, tbl[i].edone);
    end

    // Redirect with two entries queued; target 18 aligns to 16.
    do_reset();
    drive(1, 0, 0, 0); tick(); check("rd.start", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); check("rd.q1", 1, 0, 4, 1, 0);
    tick();                    check("rd.q2", 1, 0, 8, 1, 0);
    drive(0, 1, 5'd18, 0); tick(); check("rd.flush", 0, 0, 16, 1, 0);
    drive(0, 0, 0, 1); tick(); check("rd.h16", 1, 16, 20, 1, 0);
    tick();                    check("rd.h20", 1, 20, 24, 1, 0);
    tick();                    check("rd.h24", 1, 24, 28, 1, 0);
    tick();                    check("rd.h28", 1, 28, 0, 1, 0);
    tick();                    check("rd.done", 0, 0, 0, 0, 1);
    // Redirect beats start in DONE.
    drive(1, 1, 5'd24, 1); tick(); check("rs.redir", 0, 0, 24, 1, 0);
    drive(0, 0, 0, 1); tick(); check("rs.h24", 1, 24, 28, 1, 0);
    tick();                    check("rs.h28", 1, 28, 0, 1, 0);
    tick();                    check("rs.done", 0, 0, 0, 0, 1);

    // Redirect colliding with a pop: the popped word is dropped.
    do_reset();
    drive(1, 0, 0, 1); tick(); check("col.start", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1); tick(); check("col.h0", 1, 0, 4, 1, 0);
    drive(0, 1, 5'd8, 1); tick(); check("col.flush", 0, 0, 8, 1, 0);
    drive(0, 0, 0, 1); tick(); check("col.h8", 1, 8, 12, 1, 0);

    // Reset with a full queue; redirect in IDLE is ignored; start resumes at 0.
    do_reset();
    drive(1, 0, 0, 0); tick(); check("mr.start", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0); tick(); check("mr.q1", 1, 0, 4, 1, 0);
    tick();                    check("mr.q2", 1, 0, 8, 1, 0);
    rst = 1'b1; tick();        check("mr.rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 1, 5'd12, 1); tick(); check("mr.idle_redir", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1); tick(); check("mr.idle", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1); tick(); check("mr.restart", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1); tick(); check("mr.h0", 1, 0, 4, 1, 0);
    tick();                    check("mr.h4", 1, 4, 8, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_sequencer.md
# ifetch_sequencer

Instruction-fetch sequencer for the single-cycle core. It owns the program counter, drives the combinational instruction memory address, and buffers fetched words in a 2-entry queue toward decode over a valid/ready handshake. It supports stall (back-pressure), redirect (branch/jump target with queue flush), and end-of-program detection. It sits between `instr_memory` and the decode stage.

## Interface
- `PC_W`, 5, PC / memory byte-address width.
- `RESET_PC`, 0, first fetch address after `start`.
- `PC_STEP`, 4, PC increment per fetched word.
- `LAST_PC`, 28, address of the final program word; fetch stops after it.
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — reset, synchronous, active-high.
- `start` input 1 — begin fetching at `RESET_PC`; honoured in IDLE and DONE only.
- `imem_addr` output PC_W — instruction memory address, equal to the PC register.
- `imem_data` input 32 — instruction word from memory, combinational on `imem_addr`.
- `redirect` input 1 — flush the queue and continue fetching from `redirect_pc`.
- `redirect_pc` input PC_W — redirect target; bits [1:0] forced to 00.
- `inst_valid` output 1 — queue head valid.
- `inst_ready` input 1 — decode accepts the head this cycle.
- `inst_data` output 32 — queue-head instruction.
- `inst_pc` output PC_W — address of `inst_data`.
- `busy` output 1 — asserted in FETCH, and in DONE while the queue is non-empty.
- `done` output 1 — asserted in DONE with the queue empty.

## Operation
- States: IDLE, FETCH, DONE.
- Reset: state IDLE, PC = `RESET_PC`, queue empty. Outputs after reset: `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `busy`=0, `done`=0, `imem_addr`=`RESET_PC`.
- IDLE: `start`=1 → FETCH, PC ← `RESET_PC`. No capture in this cycle.
- FETCH: capture is enabled when count<2, or when count==2 and a pop occurs this cycle.
  - On capture: push {`imem_data`, PC} and set PC ← PC+`PC_STEP` (mod 2^PC_W).
  - If the captured PC == `LAST_PC`: → DONE. PC still increments, but no further captures occur.
- DONE: no captures; the queue drains. `start`=1 → FETCH with PC ← `RESET_PC` and the queue flushed.
- Pop occurs when `inst_valid` && `inst_ready`. The queue is FIFO; push and pop may occur in the same cycle. Count ranges 0..2 and never overflows.
- Redirect, when `redirect`=1 in any non-IDLE state, has top priority:
  - Queue flushed (count ← 0). Any simultaneous pop is discarded.
  - PC ← {`redirect_pc`[PC_W-1:2], 2'b00}; state ← FETCH.
  - No capture in the redirect cycle.
- `redirect` in IDLE is ignored. If `redirect` and `start` are both asserted in DONE, `redirect` wins.
- `rst` mid-operation returns everything to reset values on the next edge. The queue contents are discarded.
- PC wrap: with default parameters, `LAST_PC` stops fetch before wrap. If a redirect target lies beyond `LAST_PC`, the PC wraps modulo 2^PC_W and fetch continues until the PC equals `LAST_PC`.

## Timing
- `imem_addr` is registered (the PC). `imem_data` is sampled on the same edge as capture (zero-wait memory).
- Start to first `inst_valid`: `start` sampled at edge 0; Mem[`RESET_PC`] is captured at edge 1; `inst_valid`=1 after edge 1.
- Steady state with `inst_ready` held at 1: one instruction per cycle, with no bubbles.
- Stall: with `inst_ready`=0, the queue fills in 2 cycles, after which the PC holds.
  - On release, a pop and a capture occur in the same cycle, with no lost or duplicated words.
- Redirect at edge n: the queue is empty after n. The target word is captured at n+1 and valid after n+1, a 2-cycle penalty.
- `done` rises in the cycle after the final pop of the `LAST_PC` word.

## Test plan
- Straight run: reset, then `start`, with `inst_ready`=1 and memory preloaded.
  - `inst_pc` sequence is 0,4,8,…,28 on consecutive cycles, with `inst_data` matching Mem.
  - `done`=1 one cycle after the pc=28 pop; `busy` drops at the same time.
- Back-pressure: hold `inst_ready`=0 for 5 cycles after the first valid.
  - `imem_addr` freezes at 8. The head stays at pc 0.
  - On release, pcs 0,4,8,12 pop consecutively with no gaps or duplicates.
- Redirect: assert `redirect` with `redirect_pc`=5'd18 while the queue holds 2 entries.
  - The queue flushes and the entries are never popped.
  - The next valid has pc=16, 2 cycles later, followed by 20,24,28 and then DONE.
- Redirect colliding with a pop in the same cycle: the popped word is discarded, no extra valid appears, and the count is 0 after the edge.
- Reset mid-run: assert `rst` with the queue at count 2.
  - All outputs are 0 the next cycle and `imem_addr`=0.
  - `start` is needed to resume, which restarts from pc 0.
- Restart from DONE: pulse `start`; the fetch sequence repeats from pc 0 and `done` deasserts on the next edge.
